// File: rtl/jk_counter_ctrl_pkg.sv
// Shared encodings for the JK counter controller and its flop bank.
package jk_counter_ctrl_pkg;

  // Command opcodes as presented on cmd_op.
  typedef enum logic [1:0] {
    OP_CLEAR = 2'b00,
    OP_LOAD  = 2'b01,
    OP_UP    = 2'b10,
    OP_DOWN  = 2'b11
  } op_e;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Per-bit JK drive codes, packed as {j, k}.
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // Count commands with a zero length complete without touching the bank.
  function automatic logic is_count_op(input logic [1:0] op);
    return (op == OP_UP) || (op == OP_DOWN);
  endfunction

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH JK flip-flops sharing one clock and asynchronous active-low reset.
module jk_bank #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    logic q_q;

    // Classic JK cell: hold, reset, set or toggle on each rising edge.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        q_q <= 1'b0;
      end else begin
        unique case ({j[i], k[i]})
          2'b00:   q_q <= q_q;
          2'b01:   q_q <= 1'b0;
          2'b10:   q_q <= 1'b1;
          default: q_q <= ~q_q;
        endcase
      end
    end

    assign q[i] = q_q;
  end

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command sequencer that drives a JK flop bank as a loadable up/down counter.
module jk_counter_ctrl
  import jk_counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] j, k;
  logic [WIDTH-1:0] q_dir;
  logic [WIDTH-1:0] tog;
  logic [1:0]       code;

  jk_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk  (clk),
    .reset(reset),
    .j    (j),
    .k    (k),
    .q    (q)
  );

  // Toggle-enable chain: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    q_dir = (op_q == OP_DOWN) ? ~q : q;
    tog   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i] = 1'b1;
      for (int b = 0; b < i; b++) begin
        tog[i] = tog[i] & q_dir[b];
      end
    end
  end

  // Next-state, command capture and JK drive generation.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    data_d    = data_q;
    rem_d     = rem_q;
    j         = '0;
    k         = '0;
    code      = JK_HOLD;
    cmd_ready = reset && (state_q == IDLE);
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = op_e'(cmd_op);
          data_d = cmd_data;
          rem_d  = cmd_len;
          if (is_count_op(cmd_op) && (cmd_len == '0)) begin
            state_d = DONE;
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        for (int i = 0; i < WIDTH; i++) begin
          unique case (op_q)
            OP_CLEAR: code = JK_RST;
            OP_LOAD:  code = data_q[i] ? JK_SET : JK_RST;
            default:  code = tog[i] ? JK_TOG : JK_HOLD;
          endcase
          j[i] = code[1];
          k[i] = code[0];
        end
        if (is_count_op(op_q)) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = DONE;
          end
        end else begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Controller state; the bank itself lives in jk_bank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_CLEAR;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

endmodule
